// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative HI/LO multiply/divide unit, one bit per cycle.
// Build with MDU_DIV_EN defined to include DIV/DIVU; otherwise those op codes are ignored.
module md_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [64:0] acc;
  logic [31:0] opnd;
  logic        neg_q;

  logic        is_mul_in, is_div_in, md_req, sgn;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [64:0] mul_step;
  logic [63:0] prod;

`ifdef MDU_DIV_EN
  logic        is_div, neg_r, b_zero;
  logic [31:0] a_raw;
  logic [32:0] div_part;
  logic        div_ge;
  logic [64:0] div_step;
  logic [31:0] quo, rem;
`endif

  // Request decode and operand magnitudes; even op codes are the signed variants.
  always_comb begin
    is_mul_in = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_DIV_EN
    is_div_in = (op == OP_DIV) || (op == OP_DIVU);
`else
    is_div_in = 1'b0;
`endif
    md_req = is_mul_in || is_div_in;
    sgn    = ~op[0];
    mag_a  = (sgn && a[31]) ? (~a + 32'd1) : a;
    mag_b  = (sgn && b[31]) ? (~b + 32'd1) : b;
  end

  // acc = {carry, partial product high, multiplier shifting out at the bottom}.
  always_comb begin
    mul_sum  = acc[64:32] + (acc[0] ? {1'b0, opnd} : 33'd0);
    mul_step = {1'b0, mul_sum, acc[31:1]};
    prod     = neg_q ? (~acc[63:0] + 64'd1) : acc[63:0];
  end

`ifdef MDU_DIV_EN
  // Restoring divide: acc[63:32] = partial remainder, acc[31:0] = dividend/quotient.
  always_comb begin
    div_part = {acc[63:32], acc[31]};
    div_ge   = div_part >= {1'b0, opnd};
    div_step = div_ge ? {1'b0, div_part[31:0] - opnd, acc[30:0], 1'b1}
                      : {1'b0, div_part[31:0], acc[30:0], 1'b0};
    quo      = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem      = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start && md_req) state_nxt = RUN;
      RUN:     if (cnt == 5'd31)    state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi    <= 32'd0;
      lo    <= 32'd0;
      done  <= 1'b0;
      cnt   <= 5'd0;
      acc   <= 65'd0;
      opnd  <= 32'd0;
      neg_q <= 1'b0;
`ifdef MDU_DIV_EN
      is_div <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= 32'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && md_req) begin
            cnt   <= 5'd0;
            neg_q <= sgn & (a[31] ^ b[31]);
`ifdef MDU_DIV_EN
            is_div <= is_div_in;
            neg_r  <= sgn & a[31];
            b_zero <= (b == 32'd0);
            a_raw  <= a;
            opnd   <= is_div_in ? mag_b : mag_a;
            acc    <= is_div_in ? {33'd0, mag_a} : {33'd0, mag_b};
`else
            opnd   <= mag_a;
            acc    <= {33'd0, mag_b};
`endif
          end else if (start && op == OP_MTHI) begin
            hi <= a;
          end else if (start && op == OP_MTLO) begin
            lo <= a;
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
`ifdef MDU_DIV_EN
          acc <= is_div ? div_step : mul_step;
`else
          acc <= mul_step;
`endif
        end
        FIX: begin
          done <= 1'b1;
`ifdef MDU_DIV_EN
          if (is_div) begin
            lo <= b_zero ? 32'hFFFF_FFFF : quo;
            hi <= b_zero ? a_raw : rem;
          end else begin
            hi <= prod[63:32];
            lo <= prod[31:0];
          end
`else
          hi <= prod[63:32];
          lo <= prod[31:0];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit.
// DIV/DIVU vectors run when MDU_DIV_EN is defined; otherwise DIV must be ignored.
module tb_md_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_n, done_n, done_idx;

  md_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; returns at the falling edge after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  // Sample 40 cycles; optionally inject an MTLO request at sample index inj_at.
  task automatic observe(input int inj_at, output int bn, output int dn, output int di);
    bn = 0; dn = 0; di = -1;
    for (int i = 0; i < 40; i++) begin
      if (busy) bn++;
      if (done) begin
        dn++;
        if (di < 0) di = i;
      end
      if (i == inj_at) begin
        start = 1'b1; op = 3'b101; a = 32'h0000_1234;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    // reset, with a start request held to show reset wins
    start = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9;
    repeat (2) @(negedge clk);
    start = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    rst = 1'b0;

    // MULT -2 * 3
    issue(3'b000, 32'hFFFF_FFFE, 32'h0000_0003);
    observe(-1, busy_n, done_n, done_idx);
    check("mult_busy_cycles", busy_n, 33);
    check("mult_done_count", done_n, 1);
    check("mult_done_index", done_idx, 33);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    // MULTU max * max
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    observe(-1, busy_n, done_n, done_idx);
    check("multu_busy_cycles", busy_n, 33);
    check("multu_done_count", done_n, 1);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

`ifdef MDU_DIV_EN
    issue(3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
    observe(-1, busy_n, done_n, done_idx);
    check("div_busy_cycles", busy_n, 33);
    check("div_done_count", done_n, 1);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    issue(3'b011, 32'h0000_0007, 32'h0000_0000);
    observe(-1, busy_n, done_n, done_idx);
    check("divu0_busy_cycles", busy_n, 33);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'h0000_0007);

    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    observe(-1, busy_n, done_n, done_idx);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0000_0000);
`else
    issue(3'b010, 32'h0000_0064, 32'h0000_0007);
    observe(-1, busy_n, done_n, done_idx);
    check("nodiv_busy_cycles", busy_n, 0);
    check("nodiv_done_count", done_n, 0);
    check("nodiv_hi", hi, 32'hFFFF_FFFE);
    check("nodiv_lo", lo, 32'h0000_0001);
`endif

    // start while busy: MTLO at busy cycle 10 must be ignored
    issue(3'b000, 32'd5, 32'd6);
    observe(9, busy_n, done_n, done_idx);
    check("busy_ign_cycles", busy_n, 33);
    check("busy_ign_done_count", done_n, 1);
    check("busy_ign_hi", hi, 32'd0);
    check("busy_ign_lo", lo, 32'd30);

    // reset at busy cycle 20 aborts with no result
    issue(3'b000, 32'd3, 32'd4);
    repeat (19) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    observe(-1, busy_n, done_n, done_idx);
    check("abort_no_busy", busy_n, 0);
    check("abort_no_done", done_n, 0);

    // MTHI then MTLO
    issue(3'b100, 32'hAAAA_5555, 32'd0);
    check("mthi_hi", hi, 32'hAAAA_5555);
    check("mthi_lo", lo, 32'd0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);
    issue(3'b101, 32'h1234_5678, 32'd0);
    check("mtlo_hi", hi, 32'hAAAA_5555);
    check("mtlo_lo", lo, 32'h1234_5678);
    observe(-1, busy_n, done_n, done_idx);
    check("mtx_no_busy", busy_n, 0);
    check("mtx_no_done", done_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port start, input, 1 bit: request a new operation; sampled at a rising edge.
REQ-004 The block SHALL have the port op, input, 3 bits:
- 000 MULT
- 001 MULTU
- 010 DIV
- 011 DIVU
- 100 MTHI
- 101 MTLO
- 110/111 reserved
REQ-005 The block SHALL have the port a, input, 32 bits: operand A (rs value; multiplicand/dividend; MTHI/MTLO source).
REQ-006 The block SHALL have the port b, input, 32 bits: operand B (rt value; multiplier/divisor).
REQ-007 The block SHALL have the port busy, output, 1 bit: an operation is in progress; the datapath stalls MFHI/MFLO and new requests while it is high.
REQ-008 The block SHALL have the port done, output, 1 bit: a one-cycle pulse when HI/LO hold a new multiply/divide result.
REQ-009 The block SHALL have the port hi, output, 32 bits: the HI register, driven directly from a flop.
REQ-010 The block SHALL have the port lo, output, 32 bits: the LO register, driven directly from a flop.

Function
REQ-011 The block SHALL implement the states IDLE, RUN and FIX.
- IDLE -> RUN: start=1 with op MULT/MULTU/DIV/DIVU.
- RUN -> FIX: after 32 iteration edges.
- FIX -> IDLE: after 1 edge.
REQ-012 The block SHALL accept a request only in IDLE.
- start while busy=1 is ignored.
- Reserved op codes are ignored and leave state unchanged.
REQ-013 On the accepting edge k, the block SHALL latch a, b and op, and set busy=1.
- Later changes on a and b have no effect.
REQ-014 Iterations SHALL occur on edges k+1..k+32, one bit per edge.
- Multiply: shift-add.
- Divide: restoring shift-subtract.
- Both operate on operand magnitudes (signed ops) or raw values (unsigned ops).
REQ-015 On edge k+33 (FIX), the block SHALL apply sign correction, write HI/LO, clear busy and set done=1 for exactly the following cycle.
- busy is high for 33 cycles in total.
REQ-016 MULT/MULTU SHALL produce the 64-bit product, with HI = bits 63:32 and LO = bits 31:0.
- MULT is two's-complement; MULTU is unsigned.
REQ-017 DIV/DIVU SHALL set LO = quotient and HI = remainder.
- Signed quotient truncates toward zero.
- Signed remainder takes the sign of the dividend.
REQ-018 Divide by zero (b=0) SHALL complete with the normal latency and give LO=0xFFFFFFFF, HI=a.
REQ-019 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-020 MTHI/MTLO accepted in IDLE SHALL write a into HI/LO on the accepting edge.
- busy and done stay 0.
- The other register is unchanged.
REQ-021 HI and LO SHALL be unchanged at all times except the FIX edge, an MTHI/MTLO edge, or reset.

Reset
REQ-022 When rst=1 at a rising edge, the block SHALL go to IDLE and set busy=0, done=0, hi=0, lo=0.
- Any in-flight operation is aborted with no partial result written.
REQ-023 rst SHALL take priority over start on the same edge.
REQ-024 The first request SHALL be accepted on the first edge at which rst=0 and start=1.

Configuration
REQ-025 With macro MDU_DIV_EN defined, the block SHALL implement DIV and DIVU as specified.
REQ-026 With MDU_DIV_EN undefined, the block SHALL treat DIV and DIVU as reserved op codes, and SHALL contain no divider logic.
- Multiply and MTHI/MTLO behaviour is unchanged.

Verification
REQ-027 The bench SHALL cover reset then MULT:
- Stimulus: a=0xFFFFFFFE (-2), b=0x00000003.
- Response: busy=1 for 33 cycles; then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-028 The bench SHALL cover MULTU:
- Stimulus: a=0xFFFFFFFF, b=0xFFFFFFFF.
- Response: hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 The bench SHALL cover DIV (MDU_DIV_EN defined):
- Stimulus: a=0xFFFFFFF9 (-7), b=2.
- Response: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Also: DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-030 The bench SHALL cover start while busy:
- Stimulus: MULT a=5, b=6 accepted; at cycle 10 of busy, start with MTLO a=0x1234.
- Response: ignored; final hi=0, lo=30; a single done pulse.
REQ-031 The bench SHALL cover reset mid-operation:
- Stimulus: MULT a=3, b=4; rst=1 at busy cycle 20.
- Response: next cycle busy=0, hi=0, lo=0; no done pulse follows.
REQ-032 The bench SHALL cover MTHI/MTLO:
- Stimulus: MTHI a=0xAAAA5555, then MTLO a=0x12345678.
- Response: hi/lo update on the same edge; busy and done never assert.
- With MDU_DIV_EN undefined: DIV leaves busy=0 and hi/lo unchanged.
